// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one RV32I ALU between NREQ requesters.
//   clk, rst_n        - clock, asynchronous active-low reset
//   req_valid/ready   - per-requester handshake; ready is one-hot or zero
//   req_op1/op2/aluop - packed per-requester operands and opcode
//   rsp_valid/ready   - shared response handshake
//   rsp_id            - index of the requester owning rsp_data
//   rsp_data          - combinational ALU output of the held operation
//   stall_cnt         - saturating count of cycles lost to backpressure
module alu_arbiter #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IDW  = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*32-1:0] req_op1,
    input  logic [NREQ*32-1:0] req_op2,
    input  logic [NREQ*4-1:0]  req_aluop,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [IDW-1:0]     rsp_id,
    output logic [31:0]        rsp_data,
    output logic [15:0]        stall_cnt
);

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_XOR  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_AND  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_e;

    localparam logic [IDW-1:0] LAST_RST = IDW'(NREQ - 1);

    logic            s_valid_q, s_valid_d;
    logic [IDW-1:0]  s_id_q,    s_id_d;
    logic [31:0]     s_op1_q,   s_op1_d;
    logic [31:0]     s_op2_q,   s_op2_d;
    logic [3:0]      s_aluop_q, s_aluop_d;
    logic [IDW-1:0]  last_q,    last_d;
    logic [15:0]     stall_q,   stall_d;

    logic            any_valid, can_accept, handshake;
    logic            hi_found, lo_found;
    logic [IDW-1:0]  hi_idx, lo_idx, win_idx;
    logic [NREQ-1:0] ready_vec;
    logic [31:0]     sel_op1, sel_op2;
    logic [3:0]      sel_aluop;

    // Round-robin: the lowest valid index above last wins; if none, wrap
    // around to the lowest valid index at or below last.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (req_valid[i]) begin
                if (IDW'(i) > last_q) begin
                    if (!hi_found) begin
                        hi_found = 1'b1;
                        hi_idx   = IDW'(i);
                    end
                end else if (!lo_found) begin
                    lo_found = 1'b1;
                    lo_idx   = IDW'(i);
                end
            end
        end
        win_idx = hi_found ? hi_idx : lo_idx;
    end

    always_comb begin
        ready_vec = '0;
        sel_op1   = '0;
        sel_op2   = '0;
        sel_aluop = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (IDW'(i) == win_idx) begin
                ready_vec[i] = 1'b1;
                sel_op1      = req_op1[i*32 +: 32];
                sel_op2      = req_op2[i*32 +: 32];
                sel_aluop    = req_aluop[i*4 +: 4];
            end
        end
    end

    assign any_valid  = |req_valid;
    assign can_accept = ~s_valid_q | rsp_ready;
    assign handshake  = any_valid & can_accept;
    // Gated by rst_n so no grant is offered while reset is held.
    assign req_ready  = (rst_n && handshake) ? ready_vec : '0;

    always_comb begin
        s_valid_d = s_valid_q;
        s_id_d    = s_id_q;
        s_op1_d   = s_op1_q;
        s_op2_d   = s_op2_q;
        s_aluop_d = s_aluop_q;
        last_d    = last_q;
        stall_d   = stall_q;
        if (handshake) begin
            s_valid_d = 1'b1;
            s_id_d    = win_idx;
            s_op1_d   = sel_op1;
            s_op2_d   = sel_op2;
            s_aluop_d = sel_aluop;
            last_d    = win_idx;
        end else if (rsp_ready) begin
            s_valid_d = 1'b0;
        end
        if (any_valid && !handshake && stall_q != 16'hFFFF) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_valid_q <= 1'b0;
            s_id_q    <= '0;
            s_op1_q   <= '0;
            s_op2_q   <= '0;
            s_aluop_q <= '0;
            last_q    <= LAST_RST;
            stall_q   <= '0;
        end else begin
            s_valid_q <= s_valid_d;
            s_id_q    <= s_id_d;
            s_op1_q   <= s_op1_d;
            s_op2_q   <= s_op2_d;
            s_aluop_q <= s_aluop_d;
            last_q    <= last_d;
            stall_q   <= stall_d;
        end
    end

    // Shared ALU; undefined opcodes return zero.
    always_comb begin
        case (s_aluop_q)
            ALU_ADD:  rsp_data = s_op1_q + s_op2_q;
            ALU_SUB:  rsp_data = s_op1_q - s_op2_q;
            ALU_XOR:  rsp_data = s_op1_q ^ s_op2_q;
            ALU_OR:   rsp_data = s_op1_q | s_op2_q;
            ALU_AND:  rsp_data = s_op1_q & s_op2_q;
            ALU_SLL:  rsp_data = s_op1_q << s_op2_q[4:0];
            ALU_SRL:  rsp_data = s_op1_q >> s_op2_q[4:0];
            ALU_SRA:  rsp_data = $signed(s_op1_q) >>> s_op2_q[4:0];
            ALU_SLT:  rsp_data = {31'd0, $signed(s_op1_q) < $signed(s_op2_q)};
            ALU_SLTU: rsp_data = {31'd0, s_op1_q < s_op2_q};
            default:  rsp_data = '0;
        endcase
    end

    assign rsp_valid = s_valid_q;
    assign rsp_id    = s_id_q;
    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and randomized bench for alu_arbiter (NREQ=2).
module tb_alu_arbiter;

    localparam int unsigned NREQ = 2;
    localparam int unsigned IDW  = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  vld;
    logic [31:0] op1 [2];
    logic [31:0] op2 [2];
    logic [3:0]  opc [2];
    logic        rsp_rdy;

    logic [1:0]  req_ready;
    logic        rsp_valid;
    logic [0:0]  rsp_id;
    logic [31:0] rsp_data;
    logic [15:0] stall_cnt;
    logic [63:0] p_op1, p_op2;
    logic [7:0]  p_opc;

    assign p_op1 = {op1[1], op1[0]};
    assign p_op2 = {op2[1], op2[0]};
    assign p_opc = {opc[1], opc[0]};

    always #5 clk = ~clk;

    alu_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (vld),
        .req_ready (req_ready),
        .req_op1   (p_op1),
        .req_op2   (p_op2),
        .req_aluop (p_opc),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_rdy),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .stall_cnt (stall_cnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Transaction-level model of the shared stage.
    bit          m_valid;
    int          m_id, m_last, m_stall, granted;
    logic [31:0] m_data;

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        int unsigned sh;
        sh = b % 32;
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a ^ b;
            4'd3: return a | b;
            4'd4: return a & b;
            4'd5: return a << sh;
            4'd6: return a >> sh;
            4'd7: return a[31] ? ~((~a) >> sh) : (a >> sh);
            4'd8: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            4'd9: return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic m_reset();
        m_valid = 1'b0;
        m_id    = 0;
        m_data  = 32'd0;
        m_last  = NREQ - 1;
        m_stall = 0;
        granted = -1;
    endtask

    // Entered at posedge+1 with inputs applied; checks near the falling
    // edge, advances the model, and returns at the next posedge+1.
    task automatic cycle(input bit chk);
        int w, c;
        bit can;
        logic [1:0] er;
        #4;
        can = !m_valid || rsp_rdy;
        w = -1;
        for (int k = 1; k <= NREQ; k++) begin
            c = (m_last + k) % NREQ;
            if (w < 0 && vld[c]) w = c;
        end
        er = (can && w >= 0) ? 2'(1 << w) : 2'b00;
        if (chk) begin
            check("req_ready", {30'd0, req_ready}, {30'd0, er});
            check("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_valid});
            check("rsp_id",    {31'd0, rsp_id},    32'(m_id));
            check("rsp_data",  rsp_data,           m_data);
            check("stall_cnt", {16'd0, stall_cnt}, 32'(m_stall));
        end
        if (vld != 2'b00 && !(can && w >= 0) && m_stall < 65535) m_stall++;
        if (can && w >= 0) begin
            m_valid = 1'b1;
            m_id    = w;
            m_data  = ref_alu(opc[w], op1[w], op2[w]);
            m_last  = w;
        end else if (rsp_rdy) begin
            m_valid = 1'b0;
        end
        granted = (can && w >= 0) ? w : -1;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 4))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    task automatic rand_slot(input int i);
        op1[i] = pick();
        op2[i] = pick();
        opc[i] = 4'($urandom_range(0, 15));
    endtask

    logic [31:0] t2_exp [16];

    initial begin
        t2_exp = '{32'hFFFF_FFF4, 32'hFFFF_FFEC, 32'hFFFF_FFF4, 32'hFFFF_FFF4,
                   32'h0000_0000, 32'hFFFF_FF00, 32'h0FFF_FFFF, 32'hFFFF_FFFF,
                   32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        vld = 2'b00;
        rsp_rdy = 1'b0;
        for (int i = 0; i < 2; i++) begin
            op1[i] = '0;
            op2[i] = '0;
            opc[i] = '0;
        end

        // Reset defaults
        reset_dut();
        for (int n = 0; n < 5; n++) cycle(1);

        // Single requester, full opcode sweep
        vld = 2'b10;
        op1[1] = 32'hFFFF_FFF0;
        op2[1] = 32'h0000_0004;
        rsp_rdy = 1'b1;
        for (int k = 0; k < 16; k++) begin
            opc[1] = 4'(k);
            cycle(1);
            check("t2_data", rsp_data, t2_exp[k]);
            check("t2_id", {31'd0, rsp_id}, 32'd1);
        end
        vld = 2'b00;
        cycle(1);

        // Fairness
        reset_dut();
        op1[0] = 32'd0; op1[1] = 32'd1;
        op2[0] = 32'd0; op2[1] = 32'd0;
        opc[0] = 4'd0;  opc[1] = 4'd0;
        vld = 2'b11;
        rsp_rdy = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cycle(1);
            check("t3_id", {31'd0, rsp_id}, 32'(k % 2));
            check("t3_data", rsp_data, 32'(k % 2));
        end

        // Backpressure
        reset_dut();
        op1[0] = 32'h100; op1[1] = 32'h101;
        op2[0] = 32'd1;   op2[1] = 32'd1;
        vld = 2'b11;
        rsp_rdy = 1'b0;
        for (int n = 0; n < 5; n++) cycle(1);
        check("t4_stall", {16'd0, stall_cnt}, 32'd4);
        check("t4_id", {31'd0, rsp_id}, 32'd0);
        check("t4_data", rsp_data, 32'h101);
        check("t4_hold_rdy", {30'd0, req_ready}, 32'd0);
        rsp_rdy = 1'b1;
        #1;
        check("t4_grant1", {30'd0, req_ready}, 32'd2);
        cycle(1);
        check("t4_id1", {31'd0, rsp_id}, 32'd1);
        check("t4_data1", rsp_data, 32'h102);

        // Stall counter saturation
        rsp_rdy = 1'b0;
        for (int n = 0; n < 65540; n++) cycle(0);
        check("t5_sat", {16'd0, stall_cnt}, 32'h0000_FFFF);
        cycle(1);
        check("t5_nowrap", {16'd0, stall_cnt}, 32'h0000_FFFF);

        // Asynchronous reset during backpressure
        reset_dut();
        vld = 2'b11;
        rsp_rdy = 1'b0;
        cycle(1);
        cycle(1);
        check("t6_held", {31'd0, rsp_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_valid", {31'd0, rsp_valid}, 32'd0);
        check("t6_async_rdy", {30'd0, req_ready}, 32'd0);
        check("t6_async_stall", {16'd0, stall_cnt}, 32'd0);
        m_reset();
        @(posedge clk);
        #1;
        check("t6_rdy_in_rst", {30'd0, req_ready}, 32'd0);
        rst_n = 1'b1;
        #1;
        check("t6_first_grant", {30'd0, req_ready}, 32'd1);
        #1;
        cycle(1);
        check("t6_id", {31'd0, rsp_id}, 32'd0);

        // Randomized traffic against the model
        reset_dut();
        for (int n = 0; n < 400; n++) begin
            cycle(1);
            for (int i = 0; i < 2; i++) begin
                if (granted == i || !vld[i]) begin
                    vld[i] = 1'($urandom_range(0, 1));
                    rand_slot(i);
                end
            end
            rsp_rdy = ($urandom_range(0, 3) != 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares a single instance of the RV32I `ALU` between `NREQ` requesters, for example the EX stage and an address-generation or CSR unit. It uses round-robin arbitration and valid/ready handshakes. Granted operands are captured into one result stage that drives the ALU, and the registered result is returned on a shared response channel tagged with the requester index. A saturating counter records cycles lost to arbitration or backpressure.

## Interface
- `NREQ`, 2: number of requesters; legal range 2..8.
- `IDW`, 1: width of `rsp_id`; must satisfy 2^IDW >= NREQ.
- `clk`  in  1  : single clock; all state updates on the rising edge.
- `rst_n`  in  1  : reset, asynchronous and active-low.
- `req_valid`  in  NREQ  : bit i set = requester i presents an operation.
- `req_ready`  out  NREQ  : bit i set = requester i's operation is accepted this cycle; one-hot or zero.
- `req_op1`  in  NREQ*32  : operand 1, requester i in bits [32i+31:32i].
- `req_op2`  in  NREQ*32  : operand 2, same packing.
- `req_aluop`  in  NREQ*4  : ALU opcode, requester i in bits [4i+3:4i]. Uses the ALU encoding: ADD 0, SUB 1, XOR 2, OR 3, AND 4, SLL 5, SRL 6, SRA 7, SLT 8, SLTU 9.
- `rsp_valid`  out  1  : result stage holds a result.
- `rsp_ready`  in  1  : consumer takes the result this cycle.
- `rsp_id`  out  IDW  : index of the requester that owns the result.
- `rsp_data`  out  32  : ALU output for the held operation.
- `stall_cnt`  out  16  : saturating count of stall cycles.

## Operation
- **Result stage.** Registers `s_op1`, `s_op2`, `s_aluop`, `s_id`, and `s_valid` (which drives `rsp_valid`). `rsp_data` is the combinational output of the internal `ALU` fed from these registers. Only `rsp_data` is combinational.
- **Accept enable.** `can_accept = !s_valid | rsp_ready`. This is a full-throughput pipeline register with no skid buffer.
- **Round-robin pointer.** `last` is IDW bits wide.
  - Search order is `last+1`, `last+2`, … modulo NREQ.
  - The first index with `req_valid` set is the winner `w`.
  - `req_ready = onehot(w)` when `can_accept` is high and any `req_valid` is set; otherwise 0.
- **On accept.** A handshake happens when `req_valid[w] & req_ready[w]`. Then:
  - `s_op1`, `s_op2`, `s_aluop` load from slice `w`;
  - `s_id <= w`;
  - `s_valid <= 1`;
  - `last <= w`.
- **Pointer hold.** `last` changes only on a handshake.
- **No accept with `rsp_ready` high.** `s_valid <= 0`.
- **No accept with `rsp_ready` low.** All stage registers hold.
- **Requester rules.**
  - Once `req_valid[i]` is asserted, it and its payload stay stable until `req_ready[i]`.
  - `req_valid` must not depend combinationally on `req_ready`.
  - A valid requester is granted within NREQ accepting cycles.
- **Opcodes.** Undefined values (10..15) are accepted normally and return `rsp_data = 0`, as defined by the ALU.
- **Arithmetic.** All arithmetic is 32-bit modulo 2^32. Shift amounts use `op2[4:0]`. SLT is signed and SLTU is unsigned; both return 0 or 1 in bit 0.
- **Stall counting.** `stall_cnt` increments by 1 in every cycle where `|req_valid` is set and no handshake occurs, i.e. the stage is full and `rsp_ready` is low. It saturates at 0xFFFF, with no wrap.

## Timing
- **Reset values** (asynchronous, on `rst_n` low):
  - `s_valid` = 0, so `rsp_valid` = 0;
  - `s_id` = 0, so `rsp_id` = 0;
  - `s_op1`, `s_op2`, `s_aluop` = 0, so `rsp_data` = 0 (ADD 0+0);
  - `last` = NREQ-1, so requester 0 wins first;
  - `stall_cnt` = 0.
- **Outputs during reset.** `req_ready` is 0 while `rst_n` is low.
- **Latency.** A handshake at edge N gives `rsp_valid = 1` with the correct `rsp_data`/`rsp_id` from edge N until the edge that samples `rsp_ready = 1`.
- **Throughput.** With `rsp_ready` held high, one operation completes per cycle.
- **Back-to-back transfer.** A response handshake and a new request handshake in the same cycle replace the stage contents with no bubble.
- **Backpressure.**
  - While `rsp_valid & !rsp_ready`, `rsp_*` outputs are stable and `req_ready` = 0.
  - Pending requesters keep their relative order, because `last` is frozen.
- **Reset mid-operation.** Any held result is discarded and `rsp_valid` drops immediately, asynchronously. The pointer returns to NREQ-1.

## Test plan
1. **Reset defaults.** Reset, then keep `req_valid` = 0 for 5 cycles → `rsp_valid` = 0, `req_ready` = 0, `stall_cnt` = 0, `rsp_data` = 0.
2. **Single requester, all opcodes.** Requester 1 only, `op1 = 0xFFFF_FFF0`, `op2 = 0x0000_0004`, sweep aluop 0..15 with `rsp_ready` = 1 → one result per cycle:
   - ADD 0xFFFF_FFF4, SUB 0xFFFF_FFEC, SLL 0xFFFF_FF00, SRL 0x0FFF_FFFF, SRA 0xFFFF_FFFF;
   - SLT 1, SLTU 0;
   - opcodes 10..15 return 0;
   - `rsp_id` = 1 throughout.
3. **Fairness.** NREQ = 2, both requesters valid continuously, `rsp_ready` = 1, each issuing `ADD op1 = i, op2 = 0` → `rsp_id` sequence is 0,1,0,1,…, starting at 0 after reset.
4. **Backpressure.**
   - Both requesters valid; hold `rsp_ready` = 0 for 4 cycles after the first accept → `rsp_data`/`rsp_id` stay frozen, `req_ready` = 0, `stall_cnt` = 4.
   - Then raise `rsp_ready` → the next grant goes to requester 1 in the same cycle.
5. **Stall counter saturation.** Hold `rsp_ready` = 0 with `req_valid` asserted for 70000 cycles → `stall_cnt` = 0xFFFF and does not wrap.
6. **Asynchronous reset mid-backpressure.**
   - Assert `rst_n` low between clock edges while `rsp_valid` = 1 → `rsp_valid` falls before the next edge.
   - After release, requester 0 is granted first even if the last grant before reset was requester 0.
